// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpSra = 3'b111
  } op_t;

  // Bit positions inside the 4-bit status word {neg, ovf, carry, zero}.
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_NEG   = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and status flags for one operand pair.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       flags
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [WIDTH:0]     sum;
  logic [SHAMT_W-1:0] shamt;
  logic               carry;
  logic               ovf;

  // Decode the opcode; carry/ovf only meaningful for ADD/SUB, zero elsewhere.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    r     = '0;
    shamt = b[SHAMT_W-1:0];
    unique case (op)
      OpAdd: begin
        sum   = {1'b0, a} + {1'b0, b};
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        // Two's-complement subtract; carry=1 means no borrow.
        sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpShl:   r = a << shamt;
      OpShr:   r = a >> shamt;
      OpSra:   r = $signed(a) >>> shamt;
      default: r = '0;
    endcase
  end

  // Pack the status word.
  always_comb begin
    flags             = '0;
    flags[FLAG_ZERO]  = (r == '0);
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_NEG]   = r[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an accumulator that chains results.
// S1 holds the operands, S2 holds result and flags; latency 2, one beat per cycle.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_t              s1_op_q;
  logic             s1_acc_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic [3:0]       s2_flags_q;

  logic [WIDTH-1:0] acc_q;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_r;
  logic [3:0]       core_flags;

  // Handshake: a stage moves when the one downstream of it can take the beat.
  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    adv1     = s1_valid_q && adv2;
    in_ready = !s1_valid_q || adv2;
    // acc always holds the previous beat's result by the time this beat computes.
    core_a   = s1_acc_q ? acc_q : s1_a_q;
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (core_a),
    .b     (s1_b_q),
    .op    (s1_op_q),
    .r     (core_r),
    .flags (core_flags)
  );

  // Stage 1: capture operands whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OpAdd;
      s1_acc_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_op_q  <= op_t'(in_op);
        s1_acc_q <= in_acc;
      end
    end
  end

  // Stage 2: result register; holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
      end
      if (adv1) begin
        s2_result_q <= core_r;
        s2_flags_q  <= core_flags;
      end
    end
  end

  // Accumulator follows every beat leaving S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (adv1) begin
      acc_q <= core_r;
    end
  end

  // Output drive.
  always_comb begin
    out_valid  = s2_valid_q;
    out_result = s2_result_q;
    out_flags  = s2_flags_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8) with a behavioural reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       in_acc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [3:0] out_flags;

  int checks = 0;
  int errors = 0;

  logic [11:0] got[$];    // {flags, result} of each output transfer
  logic [11:0] exp_q[$];  // model prediction for each accepted beat
  logic [7:0]  model_acc = '0;
  bit          rand_done;
  bit          bp_done;

  alu_pipe #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  // Record every output transfer (valid & ready at the coming rising edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back({out_flags, out_result});
  end

  // Reference: plain integer arithmetic, returns {neg, ovf, carry, zero, r}.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int sh = ub % 8;
    int res = 0;
    bit c = 0;
    bit v = 0;
    logic [7:0] r;
    case (op)
      3'd0: begin res = ua + ub; c = (res > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin res = ua - ub; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: res = ua & ub;
      3'd3: res = ua | ub;
      3'd4: res = ua ^ ub;
      3'd5: res = ua << sh;
      3'd6: res = ua >> sh;
      default: res = sa >>> sh;
    endcase
    r = res[7:0];
    return {r[7], v, c, (r == 8'h00), r};
  endfunction

  // Present one beat, wait (bounded) for acceptance, log the model prediction.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic acc);
    int n = 0;
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready got %b required 1", in_ready);
    end else begin
      exp_q.push_back(model(acc ? model_acc : a, b, op));
      model_acc = exp_q[$][7:0];
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (out_result !== 8'h00) begin errors++;
      $display("FAIL reset_out_result got %h required 00", out_result); end
    checks++; if (out_flags !== 4'h0) begin errors++;
      $display("FAIL reset_out_flags got %b required 0000", out_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] da[6] = '{8'h7F, 8'h05, 8'h03, 8'h80, 8'h80, 8'h81};
    logic [7:0] db[6] = '{8'h01, 8'h05, 8'h05, 8'h03, 8'h09, 8'h01};
    logic [2:0] dop[6] = '{3'd0, 3'd1, 3'd1, 3'd7, 3'd6, 3'd5};
    logic [7:0] dr[6] = '{8'h80, 8'h00, 8'hFE, 8'hF0, 8'h40, 8'h02};
    logic [3:0] df[6] = '{4'b1100, 4'b0011, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    int n = 0;
    @(posedge clk); #1;
    got.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(da[i], db[i], dop[i], 1'b0);
    while (got.size() < 6 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (got.size() != 6) begin errors++;
      $display("FAIL directed_count got %0d required 6", got.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== {df[i], dr[i]}) begin errors++;
          $display("FAIL directed_%0d got %h required %h", i, got[i], {df[i], dr[i]}); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(posedge clk); #1;
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(8'(k), 8'(k), 3'd0, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_in_ready got %b required 0", in_ready); end
    checks++; if (exp_q.size() != 2) begin errors++;
      $display("FAIL bp_accepts got %0d required 2", exp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_flags, out_result} !== {1'b1, 4'h0, 8'h02}) begin errors++;
        $display("FAIL bp_hold got %b/%h/%h required 1/0/02", out_valid, out_flags,
                 out_result); end
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    while ((got.size() < 4 || !bp_done) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (got.size() != 4) begin errors++;
      $display("FAIL bp_count got %0d required 4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== {4'h0, 8'(2 * (i + 1))}) begin errors++;
          $display("FAIL bp_order_%0d got %h required %h", i, got[i], 8'(2 * (i + 1))); end
      end
    end
  endtask

  task automatic test_accumulate();
    int n = 0;
    @(posedge clk); #1;
    got.delete(); exp_q.delete();
    out_ready = 1'b1;
    send(8'h03, 8'h04, 3'd0, 1'b0);
    send(8'h55, 8'h0A, 3'd0, 1'b1);
    send(8'hAA, 8'h02, 3'd1, 1'b1);
    while (got.size() < 3 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (got.size() != 3) begin errors++;
      $display("FAIL acc_count got %0d required 3", got.size()); end
    else begin
      checks++; if (got[0] !== 12'h007) begin errors++;
        $display("FAIL acc_0 got %h required 007", got[0]); end
      checks++; if (got[1] !== 12'h011) begin errors++;
        $display("FAIL acc_1 got %h required 011", got[1]); end
      checks++; if (got[2] !== 12'h20F) begin errors++;
        $display("FAIL acc_2 got %h required 20F", got[2]); end
    end
  endtask

  task automatic test_reset_mid_stall();
    int n = 0;
    @(posedge clk); #1;
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    send(8'h10, 8'h20, 3'd0, 1'b0);
    send(8'h30, 8'h01, 3'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    got.delete(); exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_stall_out_valid got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_stall_in_ready got %b required 1", in_ready); end
    @(posedge clk); #1 out_ready = 1'b1;
    send(8'h99, 8'h05, 3'd0, 1'b1);
    while (got.size() < 1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (got.size() != 1) begin errors++;
      $display("FAIL rst_stall_count got %0d required 1", got.size()); end
    else begin
      checks++; if (got[0] !== 12'h005) begin errors++;
        $display("FAIL rst_stall_acc got %h required 005", got[0]); end
    end
  endtask

  task automatic test_random();
    int nb = 200;
    int n = 0;
    @(posedge clk); #1;
    got.delete(); exp_q.delete();
    rand_done = 1'b0;
    fork
      while (!rand_done) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
    end
    rand_done = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b1;
    while (got.size() < nb && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (got.size() != exp_q.size() || got.size() != nb) begin errors++;
      $display("FAIL rand_count got %0d required %0d", got.size(), nb); end
    else begin
      for (int i = 0; i < nb; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++;
          $display("FAIL rand_beat_%0d got %h required %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_accumulate();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, fully pipelined successor to the registered 4-bit ALU.
- Generalises operand width and the op set to 8 ops, including XOR and shifts.
- Adds a four-flag status word, valid/ready handshakes on both sides, and an accumulator mode that chains results.
- Sits between an operand producer (sequencer or register file) and a result sink that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..64.
- SHAMT_W, $clog2(WIDTH), derived; number of low bits of B used as shift amount.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- in_a  in  WIDTH  operand A (ignored when in_acc=1)
- in_b  in  WIDTH  operand B
- in_op  in  3  opcode (see package)
- in_acc  in  1  1: use accumulator as operand A
- out_valid  out  1  result beat present
- out_ready  in  1  sink accepts result
- out_result  out  WIDTH  result
- out_flags  out  4  {neg, ovf, carry, zero}

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, the following all go to 0 — out_valid, out_result, out_flags, accumulator, both stage-valid bits. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are dropped, including a beat stalled on out_ready=0. No partial beat ever appears on the output.
- Pipeline:
  - S1 registers {a, b, op, acc}. S2 registers {result, flags}.
  - Beat accepted on edge t appears with out_valid=1 after edge t+1, so latency is 2 cycles.
  - Throughput is 1 beat/cycle.
- Handshake:
  - adv2 = !s2_valid | out_ready
  - adv1 = s1_valid & adv2
  - in_ready = !s1_valid | adv2
  - A transfer occurs when valid & ready are both high.
  - out_result and out_flags hold stable while out_valid=1 and out_ready=0.
  - Beats leave in acceptance order. None are lost or duplicated.
  - Simultaneous accept and drain in one cycle is legal and keeps full rate.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 SRA.
- Arithmetic:
  - ADD: {carry, r} = A + B (WIDTH+1 bits).
  - SUB: {carry, r} = A + ~B + 1, so carry=1 means no borrow (A >= B unsigned).
  - Shift amount is B[SHAMT_W-1:0]; upper bits of B are ignored.
  - SRA replicates A[WIDTH-1].
- Flags:
  - zero = (r == 0), all ops.
  - neg = r[WIDTH-1], all ops.
  - carry = as defined above for ADD/SUB; 0 for all other ops.
  - ovf (ADD) = A and B have equal sign and r sign differs from A.
  - ovf (SUB) = A and B have differing sign and r sign differs from A.
  - ovf = 0 for all other ops.
- Accumulator:
  - The WIDTH-bit acc register loads r on every S1 -> S2 advance (adv1=1), for all ops.
  - When the S1 beat has acc=1, its operand A is acc, which holds the result of the immediately preceding beat.
  - No hazard exists: the preceding beat has always left S1 before the current beat computes.
  - acc is unaffected by output stalls beyond that.
- Illegal states: none. All 8 opcodes are defined and no X ever reaches the outputs.

Decomposition:
- Package alu_pkg:
  - op_t enum (3 bits, values above).
  - Flag bit indices FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVF=2, FLAG_NEG=3.
  - OP_W=3.
- Sub-module alu_core:
  - Purely combinational, parameter WIDTH.
  - Inputs: a, b, op. Outputs: r, flags.
  - Instantiated once between S1 and S2.
  - Reused by future multi-lane variants.
- alu_pipe owns the handshake, both pipeline stages and acc.

Test Plan:
- ADD A=0x7F B=0x01, out_ready=1 -> after 2 cycles result 0x80, flags neg=1 ovf=1 carry=0 zero=0.
- SUB A=0x05 B=0x05 -> 0x00, zero=1 carry=1 ovf=0 neg=0. SUB A=0x03 B=0x05 -> 0xFE, carry=0 neg=1.
- Shifts: SRA A=0x80 B=0x03 -> 0xF0. SHR A=0x80 B=0x09 (shamt 1) -> 0x40. SHL A=0x81 B=0x01 -> 0x02, carry=0.
- Backpressure: send 4 ADDs (1+1, 2+2, 3+3, 4+4) back-to-back with out_ready=0 -> in_ready drops after 2 accepts. Release out_ready -> results 2, 4, 6, 8 in order, each held stable while stalled.
- Accumulate: ADD A=3 B=4 (acc=0), then ADD B=10 acc=1, then SUB B=2 acc=1, sent back-to-back -> results 7, 17, 15.
- Reset mid-stall: 2 beats in flight, out_ready=0, pulse rst for 1 cycle. Expect the next cycle to show out_valid=0, in_ready=1 and acc=0. The next ADD with acc=1 and B=5 returns 5.
